// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings and the muldiv sequencer states.
package rv32m_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } md_state_t;

endpackage

// File: rtl/radix2_div_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step, with step counter.
module radix2_div_core
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic [5:0]      count_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN:0]   part;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    // 33-bit partial remainder: previous remainder shifted left with the next dividend bit
    part  = {rem_q, quo_q[XLEN-1]};
    ge    = part >= {1'b0, dvs_q};
    diff  = XLEN'(part - {1'b0, dvs_q});
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      rem_d = ge ? diff : part[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ge};
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign count_o     = cnt_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: single-cycle multiply, 34-cycle iterative divide.
module muldiv_unit
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  md_state_t       state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      tag_q, tag_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  logic                   div_load, div_step;
  logic [XLEN-1:0]        div_a, div_b, quo, rem;
  logic [5:0]             div_cnt;
  logic                   sgn, div_zero, div_ovf;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic [2*XLEN-1:0]      prod;

  always_comb begin
    // rs1 is signed except for MULHU; rs2 only for MULH (MUL takes the low word, sign-agnostic)
    mul_a    = $signed({~(funct3[1] & funct3[0]) & rs1_val[XLEN-1], rs1_val});
    mul_b    = $signed({~funct3[1] & rs2_val[XLEN-1], rs2_val});
    prod     = (2*XLEN)'(mul_a * mul_b);
    sgn      = ~funct3[0];
    div_zero = (rs2_val == '0);
    div_ovf  = sgn && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    div_a    = (sgn && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    div_b    = (sgn && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
  end

  radix2_div_core u_div (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (div_a),
    .divisor_i   (div_b),
    .quotient_o  (quo),
    .remainder_o (rem),
    .count_o     (div_cnt)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (!funct3[2]) begin
              valid_d  = 1'b1;
              rd_d     = rd_in;
              result_d = (funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end else if (div_zero) begin
              valid_d  = 1'b1;
              rd_d     = rd_in;
              result_d = funct3[1] ? rs1_val : '1;
            end else if (div_ovf) begin
              valid_d  = 1'b1;
              rd_d     = rd_in;
              result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
              div_load  = 1'b1;
              tag_d     = rd_in;
              is_rem_d  = funct3[1];
              neg_quo_d = sgn && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
              neg_rem_d = sgn && rs1_val[XLEN-1];
              state_d   = DIV;
            end
          end
        end
        DIV: begin
          div_step = 1'b1;
          if (div_cnt == 6'd31) begin
            state_d = FIX;
          end
        end
        FIX: begin
          valid_d  = 1'b1;
          rd_d     = tag_q;
          result_d = is_rem_q ? (neg_rem_q ? -rem : rem) : (neg_quo_q ? -quo : quo);
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      tag_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign valid  = valid_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Execute-stage RV32M multiply/divide unit consuming the two operand values read from the register file (rs1/rs2) and returning a tagged result for the writeback port (rd, data).

- Multiply is a single-cycle registered operation.
- Divide and remainder use a 32-iteration radix-2 restoring sequencer.
- `busy` and `valid` let the hazard logic stall the pipeline around division.
- `flush` discards an in-flight operation on branch mispredict or trap.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when `busy`=0.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  dividend / multiplicand.
- rs2_val  in  XLEN  divisor / multiplier.
- rd_in  in  5  destination tag, carried to rd_out.
- flush  in  1  abort any in-flight op; no `valid` is produced for it.
- busy  out  1  high while a divide is in progress; upstream must hold or stall.
- valid  out  1  one-cycle pulse; result and rd_out are meaningful.
- result  out  XLEN  registered result; holds until the next `valid`.
- rd_out  out  5  tag of the completed op; holds with result.

## Operation
- States: IDLE, DIV, FIX.
- IDLE, start=1, funct3[2]=0 (multiply):
  - Compute the 64-bit product and register the low or high word.
  - Assert `valid` next cycle; stay in IDLE.
  - Signedness: MULH s×s, MULHSU s×u, MULHU u×u; MUL returns the low 32 bits.
- IDLE, start=1, divide op, divisor=0: fast path, result next cycle. DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1_val.
- IDLE, start=1, DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF: fast path. DIV = 0x80000000; REM = 0.
- IDLE, start=1, other divide op:
  - Latch the absolute values (signed ops), the sign flags, op and tag.
  - Clear the 6-bit counter; enter DIV.
- DIV: one restoring step per cycle, with a 33-bit partial remainder. After the step at count=31, go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ (DIV).
  - Negate the remainder if the dividend was negative (REM).
  - Register the result, pulse `valid`, return to IDLE.
- `busy` = (state != IDLE).
- Multiply back-to-back: start is accepted every cycle.
- flush=1 in any cycle: next state IDLE, counter cleared, no `valid` for the aborted op. result and rd_out keep their prior values. A start in the same cycle is ignored.
- rst has priority over flush and start. Reset values: state IDLE, busy 0, valid 0, result 0, rd_out 0.
- rd_in=0 is passed through unchanged; dropping x0 writes is the register file's job.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- Multiply and divide fast paths: `valid` high in cycle 1; busy never asserted.
- Normal divide: `busy` high in cycles 1–33, `valid` high in cycle 34, `busy` low in cycle 34. A new start can be accepted in cycle 34.
- Latency is fixed regardless of operand values, so hazard logic may count cycles.
- Operands and tag are captured in cycle 0; upstream may change them from cycle 1.
- `valid` is never high for two consecutive cycles from one op. Consecutive multiplies give consecutive pulses.

## Structure
- Shared package `rv32m_pkg`:
  - funct3 constants (MUL..REMU).
  - `md_state_t` enum {IDLE, DIV, FIX}.
  - XLEN constant.
- Sub-module `radix2_div_core`: unsigned iterative quotient/remainder datapath with counter. Sign handling, fast paths and the state machine stay in the top module.
- Multiplier is an inferred 33×33 signed multiply on sign- or zero-extended operands.

## Test plan
- MULH 0xFFFFFFFF × 0xFFFFFFFF, rd=5 → cycle 1: valid, result=0x00000000, rd_out=5. Same operands with MULHU → 0xFFFFFFFE.
- DIV −7 / 2 → cycle 34: result=0xFFFFFFFD (−3), busy high in cycles 1–33. REM −7 / 2 → 0xFFFFFFFF (−1).
- DIVU 100 / 0 → cycle 1: 0xFFFFFFFF. REMU 100 / 0 → 100. DIV 0x80000000 / −1 → 0x80000000, no busy.
- Start asserted during divide cycles 1–33 → ignored, no extra valid. Flush at cycle 10 → no valid; a new MUL 3×4 in cycle 11 → 12 in cycle 12.
- rst asserted at cycle 20 of a divide → next cycle busy=0, valid=0, result=0, rd_out=0.
- Randomized back-to-back MUL/DIVU stream against a golden model → every result and tag matches, with exact latency.
